riscv_dbg_ctrl: RTL and testbench

Multi-core debug access controller for a RISC-V tile. It accepts debug commands (read, write, stall, unstall) on a valid/ready command channel and executes them on the per-core debug bus. It returns a response with read data or a timeout error on a valid/ready response channel. It sits between the tile debug unit (JTAG/host side) and the `CORES_PER_TILE` cores. It adds broadcast writes, broadcast stall/unstall, per-access timeout and breakpoint-driven stall capture.

---
 rtl/riscv_dbg_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_riscv_dbg_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dbg_ctrl.sv
// riscv_dbg_ctrl
//   Multi-core debug access controller for a RISC-V tile. Accepts debug
//   commands (read / write / stall / unstall) on a valid/ready command
//   channel, runs them on the per-core debug bus and returns one response
//   per command on a valid/ready response channel. Supports broadcast
//   writes (cores visited in index order), broadcast stall/unstall, a
//   per-access timeout and breakpoint-driven stall capture.
//
// Ports
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                00 read, 01 write, 10 stall, 11 unstall
//   cmd_core, cmd_bcast   target core index / apply to all cores
//   cmd_addr, cmd_data    debug address / write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_err     read data (0 otherwise) / timeout or bad target
//   cpu_bp_i              per-core breakpoint hit
//   cpu_stall_o           per-core stall request
//   cpu_stb_o, cpu_we_o   per-core bus strobe / write enable
//   cpu_adr_o, cpu_dat_o  per-core bus address / write data
//   cpu_dat_i, cpu_ack_i  per-core bus read data / acknowledge

module riscv_dbg_ctrl #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned PLEN           = 64,
  parameter int unsigned CORES_PER_TILE = 16,
  parameter int unsigned TIMEOUT        = 255,
  localparam int unsigned CW = (CORES_PER_TILE > 1) ? $clog2(CORES_PER_TILE) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [1:0]                          cmd_op,
  input  logic [CW-1:0]                       cmd_core,
  input  logic                                cmd_bcast,
  input  logic [PLEN-1:0]                     cmd_addr,
  input  logic [XLEN-1:0]                     cmd_data,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [XLEN-1:0]                     rsp_data,
  output logic                                rsp_err,
  input  logic [CORES_PER_TILE-1:0]           cpu_bp_i,
  output logic [CORES_PER_TILE-1:0]           cpu_stall_o,
  output logic [CORES_PER_TILE-1:0]           cpu_stb_o,
  output logic [CORES_PER_TILE-1:0]           cpu_we_o,
  output logic [CORES_PER_TILE-1:0][PLEN-1:0] cpu_adr_o,
  output logic [CORES_PER_TILE-1:0][XLEN-1:0] cpu_dat_o,
  input  logic [CORES_PER_TILE-1:0][XLEN-1:0] cpu_dat_i,
  input  logic [CORES_PER_TILE-1:0]           cpu_ack_i
);

  localparam int unsigned CNTW = 16;
  localparam logic [CNTW-1:0] TO_LAST   = CNTW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   LAST_CORE = CW'(CORES_PER_TILE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_NEXT,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_STALL   = 2'b10,
    OP_UNSTALL = 2'b11
  } op_e;

  state_e                            state_q;
  op_e                               op_q;
  logic                              bcast_q;
  logic [CW-1:0]                     tgt_q;
  logic [PLEN-1:0]                   addr_q;
  logic [XLEN-1:0]                   data_q;
  logic [CNTW-1:0]                   cnt_q;
  logic                              err_q;
  logic [CORES_PER_TILE-1:0]         stall_q, stall_d;
  logic [CORES_PER_TILE-1:0]         stb_q;
  logic [CORES_PER_TILE-1:0]         we_q;
  logic [CORES_PER_TILE-1:0][PLEN-1:0] adr_q;
  logic [CORES_PER_TILE-1:0][XLEN-1:0] dat_q;
  logic                              rsp_valid_q;
  logic [XLEN-1:0]                   rsp_data_q;
  logic                              rsp_err_q;

  logic          core_oob;
  logic          bus_op;
  logic          bad_target;
  logic [CW-1:0] first_core;
  logic          acc_ack;
  logic          acc_to;
  logic          acc_last;

  // An index can only exceed the core count when the count is not a power
  // of two; otherwise every encodable index is a real core.
  if (CORES_PER_TILE == (1 << CW)) begin : g_oob_none
    assign core_oob = 1'b0;
  end else begin : g_oob_cmp
    assign core_oob = (cmd_core > LAST_CORE);
  end

  always_comb begin
    bus_op     = (cmd_op == OP_READ) || (cmd_op == OP_WRITE);
    // Broadcast reads have no single result to return; refuse them.
    bad_target = (cmd_bcast && (cmd_op == OP_READ)) || (!cmd_bcast && core_oob);
    first_core = cmd_bcast ? '0 : cmd_core;
  end

  // Access completion: an ack wins over a timeout in the same cycle.
  always_comb begin
    acc_ack  = cpu_ack_i[tgt_q];
    acc_to   = (cnt_q == TO_LAST);
    acc_last = !bcast_q || (tgt_q == LAST_CORE);
  end

  // Stall capture: command effect first, then breakpoints OR on top so a
  // breakpoint always beats a same-cycle unstall.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && cmd_valid && !(!cmd_bcast && core_oob)) begin
      if (cmd_op == OP_STALL) begin
        if (cmd_bcast) stall_d = '1;
        else           stall_d[cmd_core] = 1'b1;
      end else if (cmd_op == OP_UNSTALL) begin
        if (cmd_bcast) stall_d = '0;
        else           stall_d[cmd_core] = 1'b0;
      end
    end
    stall_d = stall_d | cpu_bp_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      bcast_q     <= 1'b0;
      tgt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      stall_q     <= '0;
      stb_q       <= '0;
      we_q        <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= op_e'(cmd_op);
            bcast_q <= cmd_bcast;
            addr_q  <= cmd_addr;
            data_q  <= cmd_data;
            tgt_q   <= first_core;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            if (bus_op && !bad_target) begin
              state_q             <= S_ACCESS;
              stb_q[first_core]   <= 1'b1;
              we_q[first_core]    <= (cmd_op == OP_WRITE);
              adr_q[first_core]   <= cmd_addr;
              dat_q[first_core]   <= cmd_data;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= bad_target;
            end
          end
        end

        S_ACCESS: begin
          if (acc_ack || acc_to) begin
            stb_q <= '0;
            we_q  <= '0;
            if (acc_last) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= err_q | !acc_ack;
              rsp_data_q  <= (acc_ack && (op_q == OP_READ)) ? cpu_dat_i[tgt_q] : '0;
            end else begin
              // Broadcast write: remember the failure, move to the next core.
              state_q <= S_NEXT;
              err_q   <= err_q | !acc_ack;
              tgt_q   <= tgt_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // One idle bus cycle between broadcast cores, then strobe the next.
        S_NEXT: begin
          state_q       <= S_ACCESS;
          cnt_q         <= '0;
          stb_q[tgt_q]  <= 1'b1;
          we_q[tgt_q]   <= 1'b1;
          adr_q[tgt_q]  <= addr_q;
          dat_q[tgt_q]  <= data_q;
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign cpu_stall_o = cpu_bp_i | stall_q;
  assign cpu_stb_o   = stb_q;
  assign cpu_we_o    = we_q;
  assign cpu_adr_o   = adr_q;
  assign cpu_dat_o   = dat_q;

endmodule

// File: tb/tb_riscv_dbg_ctrl.sv
// tb_riscv_dbg_ctrl
//   Self-checking bench for riscv_dbg_ctrl. Per-core bus responders ack after
//   a configurable number of strobe cycles (or never); a transaction-level
//   reference derives pulse lengths, latency, error and data, and a stall
//   model tracks the stall register from command and breakpoint rules.

module tb_riscv_dbg_ctrl;

  localparam int unsigned XLEN = 64;
  localparam int unsigned PLEN = 64;
  localparam int unsigned N    = 16;
  localparam int unsigned CW   = 4;
  localparam int          TO   = 8;
  localparam int          LIMIT = 400;

  logic                   clk, rst;
  logic                   cmd_valid, cmd_ready, cmd_bcast;
  logic [1:0]             cmd_op;
  logic [CW-1:0]          cmd_core;
  logic [PLEN-1:0]        cmd_addr;
  logic [XLEN-1:0]        cmd_data;
  logic                   rsp_valid, rsp_ready, rsp_err;
  logic [XLEN-1:0]        rsp_data;
  logic [N-1:0]           cpu_bp_i, cpu_stall_o, cpu_stb_o, cpu_we_o, cpu_ack_i;
  logic [N-1:0][PLEN-1:0] cpu_adr_o;
  logic [N-1:0][XLEN-1:0] cpu_dat_o, cpu_dat_i;

  riscv_dbg_ctrl #(
    .XLEN(XLEN),
    .PLEN(PLEN),
    .CORES_PER_TILE(N),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_core(cmd_core), .cmd_bcast(cmd_bcast), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .cpu_bp_i(cpu_bp_i), .cpu_stall_o(cpu_stall_o), .cpu_stb_o(cpu_stb_o),
    .cpu_we_o(cpu_we_o), .cpu_adr_o(cpu_adr_o), .cpu_dat_o(cpu_dat_o),
    .cpu_dat_i(cpu_dat_i), .cpu_ack_i(cpu_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_en = 0;
  int          dly[N];          // ack after dly+1 strobe cycles; <0 never
  logic [N-1:0] bp_force = '0;
  bit          bp_rand = 0;
  logic [N-1:0] bpv;
  logic [N-1:0] stall_m;
  int          hi[N];
  int          pc[$];           // observed strobe pulses: core, length
  int          pl[$];
  logic [XLEN-1:0] ack_data;
  logic [PLEN-1:0] cur_addr = '0;
  logic [XLEN-1:0] cur_data = '0;
  logic            cur_we = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int plen(input int d);
    return (d >= 0 && d < TO) ? d + 1 : TO;
  endfunction

  function automatic bit acked(input int d);
    return (d >= 0 && d < TO);
  endfunction

  function automatic int rand_dly();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return r % 4;
    if (r == 6) return -1;
    if (r == 7) return TO - 1;
    if (r == 8) return TO;
    return 1;
  endfunction

  // Bus responders, breakpoint source, per-cycle checks and stall model.
  initial begin
    stall_m   = '0;
    cpu_ack_i = '0;
    cpu_bp_i  = '0;
    cpu_dat_i = '0;
    ack_data  = '0;
    for (int p = 0; p < N; p++) hi[p] = 0;
    forever begin
      @(negedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
        cpu_dat_i[p] = {$urandom, $urandom};
        if (cpu_stb_o[p]) begin
          hi[p]++;
          cpu_ack_i[p] = (dly[p] >= 0) && (hi[p] - 1 == dly[p]);
          if (cpu_ack_i[p]) ack_data = cpu_dat_i[p];
        end else begin
          if (hi[p] > 0) begin
            pc.push_back(p);
            pl.push_back(hi[p]);
          end
          hi[p] = 0;
          cpu_ack_i[p] = ($urandom_range(0, 3) == 0);
        end
      end
      bpv = bp_force;
      if (bp_rand)
        for (int p = 0; p < N; p++)
          if ($urandom_range(0, 15) == 0) bpv[p] = 1'b1;
      cpu_bp_i = bpv;
      #1;
      if (chk_en) begin
        chk("stall_o", 64'(cpu_stall_o), 64'(bpv | stall_m));
        chk("stb_onehot", 64'($countones(cpu_stb_o) <= 1), 64'd1);
        chk("we_without_stb", 64'(cpu_we_o & ~cpu_stb_o), 64'd0);
        for (int p = 0; p < N; p++)
          if (cpu_stb_o[p]) begin
            chk("bus_adr", cpu_adr_o[p], cur_addr);
            chk("bus_we", 64'(cpu_we_o[p]), 64'(cur_we));
            chk("bus_dat", cpu_dat_o[p], cur_data);
          end
      end
      if (rst) stall_m = '0;
      else begin
        if (cmd_valid) begin
          if (cmd_op == 2'b10) begin
            if (cmd_bcast) stall_m = '1;
            else           stall_m[cmd_core] = 1'b1;
          end else if (cmd_op == 2'b11) begin
            if (cmd_bcast) stall_m = '0;
            else           stall_m[cmd_core] = 1'b0;
          end
        end
        stall_m = stall_m | bpv;
      end
    end
  end

  task automatic run_cmd(input logic [1:0] op, input int core, input logic bc,
                         input logic [63:0] addr, input logic [63:0] data,
                         input int hold);
    int ec[$];
    int el[$];
    int lat, lat_e, sum;
    logic err_e;
    logic [XLEN-1:0] data_e;

    err_e = 1'b0;
    lat_e = 1;
    if (op == 2'b00 || op == 2'b01) begin
      if (bc && op == 2'b00) begin
        err_e = 1'b1;
      end else if (bc) begin
        sum = 0;
        for (int p = 0; p < N; p++) begin
          ec.push_back(p);
          el.push_back(plen(dly[p]));
          sum += plen(dly[p]);
          if (!acked(dly[p])) err_e = 1'b1;
        end
        lat_e = sum + N;
      end else begin
        ec.push_back(core);
        el.push_back(plen(dly[core]));
        err_e = !acked(dly[core]);
        lat_e = plen(dly[core]) + 1;
      end
    end

    @(negedge clk);
    pc.delete();
    pl.delete();
    ack_data  = '0;
    cur_addr  = addr;
    cur_data  = data;
    cur_we    = (op == 2'b01);
    cmd_op    = op;
    cmd_core  = CW'(core);
    cmd_bcast = bc;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    #3;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    #3;
    while (!rsp_valid && lat < LIMIT) begin
      @(negedge clk);
      #3;
      lat++;
    end
    chk("latency", 64'(lat), 64'(lat_e));

    data_e = (op == 2'b00 && !bc && acked(dly[core])) ? ack_data : '0;
    chk("pulse_count", 64'(pc.size()), 64'(ec.size()));
    for (int i = 0; i < ec.size(); i++)
      if (i < pc.size()) begin
        chk("pulse_core", 64'(pc[i]), 64'(ec[i]));
        chk("pulse_len", 64'(pl[i]), 64'(el[i]));
      end

    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_data", rsp_data, data_e);
      chk("hold_err", 64'(rsp_err), 64'(err_e));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      #3;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_data", rsp_data, data_e);
    chk("rsp_err", 64'(rsp_err), 64'(err_e));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #3;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("ready_after_rsp", 64'(cmd_ready), 64'd1);
  endtask

  task automatic set_dly(input int d);
    for (int p = 0; p < N; p++) dly[p] = d;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_core  = '0;
    cmd_bcast = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    set_dly(0);

    repeat (2) @(negedge clk);
    chk_en = 1;
    #3;
    chk("rst_stb", 64'(cpu_stb_o), 64'd0);
    chk("rst_we", 64'(cpu_we_o), 64'd0);
    chk("rst_adr3", cpu_adr_o[3], 64'd0);
    chk("rst_dat3", cpu_dat_o[3], 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("cmd_ready_post_rst", 64'(cmd_ready), 64'd1);

    // Read core 3, acked in the third strobe cycle.
    set_dly(0);
    dly[3] = 2;
    run_cmd(2'b00, 3, 1'b0, 64'h1000, 64'h0, 0);

    // Write core 0, never acked: full timeout, then a normal command.
    dly[0] = -1;
    run_cmd(2'b01, 0, 1'b0, 64'h40, 64'h1234_5678_9abc_def0, 1);
    run_cmd(2'b00, 1, 1'b0, 64'h88, 64'h0, 0);

    // Ack in the final allowed cycle is a success; one cycle later is not.
    dly[2] = TO - 1;
    run_cmd(2'b00, 2, 1'b0, 64'h90, 64'h0, 0);
    dly[2] = TO;
    run_cmd(2'b00, 2, 1'b0, 64'h98, 64'h0, 0);

    // Broadcast write, core 5 silent.
    set_dly(0);
    dly[5] = -1;
    run_cmd(2'b01, 0, 1'b1, 64'h20, 64'hDEAD_BEEF, 0);

    // Broadcast read is refused.
    run_cmd(2'b00, 4, 1'b1, 64'h20, 64'h0, 0);

    // Broadcast stall, then unstall core 2 against its breakpoint.
    run_cmd(2'b10, 0, 1'b1, 64'h0, 64'h0, 0);
    bp_force[2] = 1'b1;
    run_cmd(2'b11, 2, 1'b0, 64'h0, 64'h0, 0);
    bp_force = '0;
    @(negedge clk);
    #3;
    chk("stall_kept", 64'(cpu_stall_o), 64'hFFFF);

    // Response back-pressure for 10 cycles.
    set_dly(1);
    run_cmd(2'b00, 9, 1'b0, 64'h300, 64'h0, 10);

    // Reset in the middle of an access.
    set_dly(0);
    dly[7] = -1;
    @(negedge clk);
    cur_addr  = 64'h700;
    cur_data  = 64'h77;
    cur_we    = 1'b0;
    cmd_op    = 2'b00;
    cmd_core  = 4'd7;
    cmd_bcast = 1'b0;
    cmd_addr  = 64'h700;
    cmd_data  = 64'h77;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #3;
    chk("pre_rst_stb7", 64'(cpu_stb_o[7]), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #3;
    chk("mid_rst_stb", 64'(cpu_stb_o), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_stall", 64'(cpu_stall_o), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);

    // Randomized commands with random breakpoints and responder delays.
    bp_rand = 1;
    for (int k = 0; k < 80; k++) begin
      int core;
      logic bc;
      logic [1:0] op;
      for (int p = 0; p < N; p++) dly[p] = rand_dly();
      op   = 2'($urandom_range(0, 3));
      core = int'($urandom_range(0, N - 1));
      bc   = ($urandom_range(0, 5) == 0);
      run_cmd(op, core, bc, {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, 3)));
    end
    bp_rand = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
